// File: rtl/ring_seek_decoder_pkg.sv
// Shared definitions for the 16-position ring seek decoder.
//   RING_N  : number of ring positions (one-hot width)
//   RING_W  : width of a binary position code
//   state_t : seek controller states (IDLE / SEEK)
// Build option: RING_BIDIR_EN (see ring_seek_decoder.sv) does not change this package.
package ring_pkg;

  localparam int RING_N = 16;
  localparam int RING_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEEK = 1'b1
  } state_t;

endpackage

// File: rtl/ring_seek_decoder_if.sv
// Bus bundle for ring_seek_decoder.
// Handshake: a code transfers on a rising CLK edge where in_valid and
// in_ready are both 1. in_ready is 1 only while the block is IDLE; during
// a seek in_valid is ignored and nothing is queued.
//   in_valid  : master -> slave, in_code is meaningful
//   in_code   : master -> slave, binary target position
//   in_ready  : slave  -> master, block can take a code
//   Q         : one-hot ring, Q[i]=1 means position i
//   C         : current binary position (registered)
//   busy      : seek in progress
//   done      : one-cycle pulse when the ring reaches the target
//   err       : sticky ring/position disagreement flag
//   state_dbg : current controller state, for observation only
interface ring_seek_decoder_if;
  import ring_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [RING_W-1:0] in_code;
  logic [0:RING_N-1] Q;
  logic [RING_W-1:0] C;
  logic              busy;
  logic              done;
  logic              err;
  state_t            state_dbg;

  modport master (
    output in_valid, in_code,
    input  in_ready, Q, C, busy, done, err, state_dbg
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, Q, C, busy, done, err, state_dbg
  );

endinterface

// File: rtl/ring_seek_decoder_onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder.
//   code : binary position, RING_W bits
//   oh   : one-hot vector [0:RING_N-1], oh[code]=1
module onehot_dec
  import ring_pkg::*;
(
  input  logic [RING_W-1:0] code,
  output logic [0:RING_N-1] oh
);

  always_comb begin
    oh       = '0;
    oh[code] = 1'b1;
  end

endmodule

// File: rtl/ring_seek_decoder.sv
// ring_seek_decoder: accepts a binary target code and steps a registered
// one-hot ring one position per clock until it reaches that target, then
// pulses done. The ring drives Q, the matching binary position drives C.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset (loads RESET_POS, IDLE)
//   bus   : ring_seek_decoder_if.slave (handshake, Q, C, busy, done, err, state_dbg)
// Parameter:
//   RESET_POS : ring position loaded at reset (0..15)
// Build option:
//   RING_BIDIR_EN defined   -> shortest path; backward when distance > 8
//   RING_BIDIR_EN undefined -> forward rotation only
module ring_seek_decoder
  import ring_pkg::*;
#(
  parameter int RESET_POS = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  ring_seek_decoder_if.slave bus
);

  localparam logic [RING_W-1:0] RESET_CODE = RING_W'(RESET_POS);

  state_t            state, state_nxt;
  logic [0:RING_N-1] ring, ring_nxt;
  logic [RING_W-1:0] pos, pos_nxt;
  logic [RING_W-1:0] target, target_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic [0:RING_N-1] reset_oh;
  logic [0:RING_N-1] pos_oh;

`ifdef RING_BIDIR_EN
  // dir=1 means the ring walks backward for the current seek.
  logic              dir, dir_nxt;
  logic [RING_W-1:0] dist;
  assign dist = bus.in_code - pos;
`endif

  onehot_dec u_reset_oh (
    .code (RESET_CODE),
    .oh   (reset_oh)
  );

  // Reference one-hot of the binary position, used for the integrity check.
  onehot_dec u_pos_oh (
    .code (pos),
    .oh   (pos_oh)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      ring   <= reset_oh;
      pos    <= RESET_CODE;
      target <= RESET_CODE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef RING_BIDIR_EN
      dir    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      ring   <= ring_nxt;
      pos    <= pos_nxt;
      target <= target_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
`ifdef RING_BIDIR_EN
      dir    <= dir_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    ring_nxt   = ring;
    pos_nxt    = pos;
    target_nxt = target;
    done_nxt   = 1'b0;
    // Sticky: the ring register and the binary position must always agree.
    err_nxt    = err_q | (ring != pos_oh);
`ifdef RING_BIDIR_EN
    dir_nxt    = dir;
`endif

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          target_nxt = bus.in_code;
          state_nxt  = SEEK;
`ifdef RING_BIDIR_EN
          // Distance of exactly half the ring goes forward.
          dir_nxt    = (dist > RING_W'(RING_N / 2));
`endif
        end
      end
      SEEK: begin
        if (pos == target) begin
          // Arrival is detected one edge after the last step, so a zero
          // distance seek still takes one edge and leaves the ring alone.
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
`ifdef RING_BIDIR_EN
          if (dir) begin
            ring_nxt = {ring[1:RING_N-1], ring[0]};
            pos_nxt  = pos - RING_W'(1);
          end else begin
            ring_nxt = {ring[RING_N-1], ring[0:RING_N-2]};
            pos_nxt  = pos + RING_W'(1);
          end
`else
          ring_nxt = {ring[RING_N-1], ring[0:RING_N-2]};
          pos_nxt  = pos + RING_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == SEEK);
  assign bus.Q         = ring;
  assign bus.C         = pos;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_ring_seek_decoder.sv
// Testbench for ring_seek_decoder. Works with or without RING_BIDIR_EN.
module tb_ring_seek_decoder;
  import ring_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_N;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  ring_seek_decoder_if bus ();

  ring_seek_decoder #(.RESET_POS(0)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int tests_run;
  int tests_failed;
  int m_pos;                       // model position of the ring
  logic [RING_W-1:0] exp_q[$];     // targets in acceptance order

  function automatic logic [0:15] oh(input int p);
    logic [0:15] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input bit b, input bit d, input bit e);
    chk({tag, ".C"}, 32'(bus.C), 32'(p));
    chk({tag, ".Q"}, 32'(bus.Q), 32'(oh(p)));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'(!b));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
    chk({tag, ".err"}, 32'(bus.err), 32'(e));
  endtask

  // ---------------- driver tasks ----------------
  // Asserts reset now (asynchronously), checks, releases on a falling edge.
  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    m_pos = 0;
    chk_all({tag, ".async"}, 0, 0, 0, 0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk_all({tag, ".held"}, 0, 0, 0, 0);
  endtask

  // Called right after a falling edge with the block idle (or in its done
  // cycle). Returns right after the falling edge of the done cycle.
  task automatic do_seek(input string tag, input logic [3:0] code, input bit hold);
    int d, steps, start, p;
    bit back;
    start = m_pos;
    d     = (int'(code) - start + 16) % 16;
    steps = d;
    back  = 1'b0;
`ifdef RING_BIDIR_EN
    if (d > 8) begin
      back  = 1'b1;
      steps = 16 - d;
    end
`endif
    chk({tag, ".accept_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    exp_q.push_back(code);
    @(posedge CLK);
    #1;
    if (hold) bus.in_code = 4'($urandom_range(0, 15));
    else      bus.in_valid = 1'b0;
    for (int t = 0; t <= steps; t++) begin
      @(negedge CLK);
      p = back ? (start - t + 16) % 16 : (start + t) % 16;
      chk_all({tag, ".step"}, p, 1, 0, 0);
      if (hold) bus.in_code = 4'($urandom_range(0, 15));
      @(posedge CLK);
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    m_pos = int'(exp_q.pop_front());
    chk_all({tag, ".done"}, m_pos, 0, 1, 0);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge CLK);
    @(negedge CLK);
    chk_all(tag, m_pos, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:15] bad;
    tests_run    = 0;
    tests_failed = 0;
    m_pos        = 0;
    RST_N        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all("por", 0, 0, 0, 0);
    RST_N = 1'b1;

    // Forward seek 0 -> 5, then zero distance 5 -> 5.
    do_seek("fwd5", 4'd5, 1'b0);
    idle_cycle("fwd5.after");
    do_seek("zero5", 4'd5, 1'b0);
    idle_cycle("zero5.after");

    // Wrap: 14 -> 2 (back-to-back from the done cycle of the first seek).
    do_seek("to14", 4'd14, 1'b0);
    do_seek("wrap2", 4'd2, 1'b0);
    idle_cycle("wrap2.after");

    // Direction: 0 -> 15 and 0 -> 8.
    do_seek("to0", 4'd0, 1'b0);
    do_seek("dir15", 4'd15, 1'b0);
    do_seek("to0b", 4'd0, 1'b0);
    do_seek("dir8", 4'd8, 1'b0);
    idle_cycle("dir8.after");

    // Reset during a seek 0 -> 12 after four steps.
    do_reset("rst1");
    bus.in_valid = 1'b1;
    bus.in_code  = 4'd12;
    @(posedge CLK);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("midseek.C4", 32'(bus.C), 32'd4);
    do_reset("rst_mid");

    // Resume with in_valid held high throughout the seek.
    do_seek("resume12", 4'd12, 1'b1);
    idle_cycle("resume12.after");

    // Corrupt the ring with an extra bit at position 3.
    do_seek("to5", 4'd5, 1'b0);
    idle_cycle("to5.after");
    bad    = oh(m_pos);
    bad[3] = 1'b1;
    force dut.ring = bad;
    @(posedge CLK);
    #1 release dut.ring;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("err.sticky", 32'(bus.err), 32'd1);
      @(posedge CLK);
    end
    @(negedge CLK);
    do_reset("rst_err");

    // Random targets, random gaps, random held in_valid.
    for (int i = 0; i < 25; i++) begin
      do_seek("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle("rand.idle");
    end
    idle_cycle("final.idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
